multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Control sequencer that runs the RV64 datapath (PC register, IMEM, RegFile_32, ALU, data memory) as a multi-cycle machine: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Drives the datapath control lines: branch, mem_read/mem_write, mem_to_reg, alu_op, alu_src2_sel, wr_en, plus PC/IR write enables.
- Handshakes with instruction and data memories through req/ready.
- Keeps cycle and retired-instruction counters, and traps on illegal opcodes or memory timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles a memory req may wait for ready before a bus-error trap.
- CNT_W, 64: width of cycle_count and instret_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset: sampled on the rising edge of clk, and the block resets when reset==0
- opcode  in  7  instruction[6:0] taken from the instruction register
- imem_ready  in  1  instruction memory has the word valid this cycle
- dmem_ready  in  1  data memory access completes this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- ir_write  out  1  latch the fetched instruction into the IR
- pc_write  out  1  update the PC from the PC mux
- branch  out  1  branch qualifier; the datapath ANDs it with alu_zero
- mem_read  out  1  data memory read
- mem_write  out  1  data memory write
- mem_to_reg  out  1  write-back source select (1 = memory data)
- alu_op  out  2  00 = add, 01 = subtract for branch compare, 10 = decode by funct
- alu_src2_sel  out  1  1 = immediate, 0 = rs2
- wr_en  out  1  register file write enable
- illegal_instr  out  1  sticky: illegal-opcode trap
- bus_error  out  1  sticky: memory timeout trap
- cycle_count  out  CNT_W  cycles since reset, excluding cycles in TRAP
- instret_count  out  CNT_W  retired instructions

Behaviour:
- Reset:
  - state = FETCH.
  - All control outputs = 0, both counters = 0, both trap flags = 0.
  - Reset applied mid-instruction abandons it. No pc_write or wr_en is issued in the reset cycle.
- Output timing:
  - Outputs are Moore, decoded from the registered state only.
  - Exception: pc_write and ir_write are qualified combinationally by ready, as listed below.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1 for that cycle, then go to DECODE.
- DECODE:
  - Evaluate opcode.
  - 0110011 (R-type), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH) go to EXEC.
  - Any other opcode sets illegal_instr and goes to TRAP.
- EXEC:
  - R-type: alu_op=10, alu_src2_sel=0, then WB.
  - I-ALU: alu_op=10, alu_src2_sel=1, then WB.
  - LOAD/STORE: alu_op=00, alu_src2_sel=1, then MEM.
  - BRANCH: alu_op=01, alu_src2_sel=0, branch=1, pc_write=1; the instruction retires and the next state is FETCH.
- MEM:
  - dmem_req=1; mem_read=1 for LOAD, mem_write=1 for STORE.
  - Request and control lines are held stable until dmem_ready.
  - On dmem_ready: LOAD goes to WB; STORE asserts pc_write=1 in that cycle, retires, and goes to FETCH.
- WB:
  - wr_en=1; mem_to_reg=1 for LOAD, else 0.
  - pc_write=1, retire, go to FETCH.
- TRAP:
  - Absorbing state. All control outputs are 0 and counters freeze.
  - The only exit is reset.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments on each cycle without ready.
  - When the count reaches TIMEOUT with ready still low: set bus_error, go to TRAP.
  - If ready arrives in the same cycle the count reaches TIMEOUT, ready wins.
- Latency with zero-wait memories: R/I = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3.
- Ready asserted in a state that does not request it is ignored.
- Counters:
  - cycle_count increments every non-TRAP cycle.
  - instret_count increments in each cycle where pc_write=1.
  - Both wrap modulo 2^CNT_W.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - opcode localparams OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALU_OP_ADD/SUB/FUNCT encodings.
- One natural sub-module, ctrl_opcode_decode: combinational opcode to instruction class plus illegal flag.

Test Plan:
- Reset (reset=0 for 2 cycles), release, zero-wait memories, opcode=0110011 → FETCH/DECODE/EXEC/WB; wr_en=1 and pc_write=1 in cycle 4; instret_count=1, cycle_count=4.
- LOAD (0000011) with dmem_ready delayed 3 cycles → mem_read and dmem_req held for 4 cycles; WB with mem_to_reg=1; retires in cycle 8.
- BRANCH (1100011) → branch=1, alu_op=01, pc_write=1 in cycle 3; wr_en never asserted.
- opcode=1111111 → illegal_instr=1 after DECODE; outputs stay 0 for 20 cycles; counters frozen.
- imem_ready held low with TIMEOUT=4 → bus_error=1 after 4 waiting cycles; a repeat run with ready arriving on the 4th wait cycle completes the fetch normally.
- STORE in MEM with reset dropped to 0 mid-wait → next cycle in FETCH, all outputs and counters 0, no pc_write.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// States, instruction classes, opcodes and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } iclass_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: maps instruction[6:0] to a class,
// flagging anything outside the supported subset as illegal.
module ctrl_opcode_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output iclass_e    cls_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o     = CLS_R;
        illegal_o = 1'b0;
        unique case (1'b1)
            opcode_i == OP_R:      cls_o = CLS_R;
            opcode_i == OP_I:      cls_o = CLS_I;
            opcode_i == OP_LOAD:   cls_o = CLS_LOAD;
            opcode_i == OP_STORE:  cls_o = CLS_STORE;
            opcode_i == OP_BRANCH: cls_o = CLS_BRANCH;
            default:               illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV64 control sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory handshakes, wait timeout, sticky traps and perf counters.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             alu_src2_sel,
    output logic             wr_en,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    iclass_e           cls_q, cls_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ill_q, ill_d;
    logic              bus_q, bus_d;
    logic [CNT_W-1:0]  cyc_q, ret_q;

    iclass_e dec_cls;
    logic    dec_ill;

    logic       imem_req_c, dmem_req_c, ir_write_c, pc_write_c;
    logic       branch_c, mem_read_c, mem_write_c, mem_to_reg_c;
    logic [1:0] alu_op_c;
    logic       alu_src2_c, wr_en_c;

    ctrl_opcode_decode u_dec (
        .opcode_i  (opcode),
        .cls_o     (dec_cls),
        .illegal_o (dec_ill)
    );

    // wait_d defaults to zero so the counter is clear on every state entry
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        wait_d       = '0;
        ill_d        = ill_q;
        bus_d        = bus_q;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_op_c     = ALU_OP_ADD;
        alu_src2_c   = 1'b0;
        wr_en_c      = 1'b0;
        unique case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    state_d    = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    bus_d   = 1'b1;
                    state_d = TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECODE: begin
                cls_d = dec_cls;
                if (dec_ill) begin
                    ill_d   = 1'b1;
                    state_d = TRAP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                unique case (cls_q)
                    CLS_R: begin
                        alu_op_c = ALU_OP_FUNCT;
                        state_d  = WB;
                    end
                    CLS_I: begin
                        alu_op_c   = ALU_OP_FUNCT;
                        alu_src2_c = 1'b1;
                        state_d    = WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src2_c = 1'b1;
                        state_d    = MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op_c   = ALU_OP_SUB;
                        branch_c   = 1'b1;
                        pc_write_c = 1'b1;
                        state_d    = FETCH;
                    end
                    default: state_d = TRAP;
                endcase
            end
            MEM: begin
                dmem_req_c  = 1'b1;
                mem_read_c  = (cls_q == CLS_LOAD);
                mem_write_c = (cls_q == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_q == CLS_LOAD) begin
                        state_d = WB;
                    end else begin
                        pc_write_c = 1'b1;
                        state_d    = FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_d   = 1'b1;
                    state_d = TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WB: begin
                wr_en_c      = 1'b1;
                mem_to_reg_c = (cls_q == CLS_LOAD);
                pc_write_c   = 1'b1;
                state_d      = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            cls_q   <= CLS_R;
            wait_q  <= '0;
            ill_q   <= 1'b0;
            bus_q   <= 1'b0;
            cyc_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            ill_q   <= ill_d;
            bus_q   <= bus_d;
            if (state_q != TRAP) cyc_q <= cyc_q + CNT_W'(1);
            if (pc_write_c)      ret_q <= ret_q + CNT_W'(1);
        end
    end

    // Reset masks every strobe so an abandoned instruction writes nothing
    assign imem_req      = reset & imem_req_c;
    assign dmem_req      = reset & dmem_req_c;
    assign ir_write      = reset & ir_write_c;
    assign pc_write      = reset & pc_write_c;
    assign branch        = reset & branch_c;
    assign mem_read      = reset & mem_read_c;
    assign mem_write     = reset & mem_write_c;
    assign mem_to_reg    = reset & mem_to_reg_c;
    assign alu_op        = reset ? alu_op_c : 2'b00;
    assign alu_src2_sel  = reset & alu_src2_c;
    assign wr_en         = reset & wr_en_c;
    assign illegal_instr = ill_q;
    assign bus_error     = bus_q;
    assign cycle_count   = cyc_q;
    assign instret_count = ret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm against a
// per-instruction cycle-trace model built from the sequencing rules.
module tb_multicycle_control_fsm;

    localparam int TMO = 4;

    localparam logic [11:0] IREQ = 12'h800;
    localparam logic [11:0] DREQ = 12'h400;
    localparam logic [11:0] IRW  = 12'h200;
    localparam logic [11:0] PCW  = 12'h100;
    localparam logic [11:0] BR   = 12'h080;
    localparam logic [11:0] MRD  = 12'h040;
    localparam logic [11:0] MWR  = 12'h020;
    localparam logic [11:0] M2R  = 12'h010;
    localparam logic [11:0] AFN  = 12'h008;
    localparam logic [11:0] ASUB = 12'h004;
    localparam logic [11:0] SRC2 = 12'h002;
    localparam logic [11:0] WREN = 12'h001;

    localparam int EV_NONE = 0;
    localparam int EV_RET  = 1;
    localparam int EV_ILL  = 2;
    localparam int EV_BUS  = 3;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        imem_ready, dmem_ready;
    logic        imem_req, dmem_req, ir_write, pc_write, branch;
    logic        mem_read, mem_write, mem_to_reg, alu_src2_sel, wr_en;
    logic [1:0]  alu_op;
    logic        illegal_instr, bus_error;
    logic [63:0] cycle_count, instret_count;
    logic [11:0] ctl;

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] m_cyc, m_ret;
    logic        m_ill, m_bus, m_trap;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.TIMEOUT(TMO), .CNT_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .branch        (branch),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .alu_op        (alu_op),
        .alu_src2_sel  (alu_src2_sel),
        .wr_en         (wr_en),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    assign ctl = {imem_req, dmem_req, ir_write, pc_write, branch, mem_read,
                  mem_write, mem_to_reg, alu_op, alu_src2_sel, wr_en};

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rnd();
        return 1'($urandom);
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011;
    endfunction

    function automatic logic [6:0] op_of(input int k);
        logic [6:0] op;
        case (k)
            K_R:  op = 7'b0110011;
            K_I:  op = 7'b0010011;
            K_LD: op = 7'b0000011;
            K_ST: op = 7'b0100011;
            K_BR: op = 7'b1100011;
            default: begin
                op = 7'($urandom_range(0, 127));
                while (is_legal(op)) op = 7'($urandom_range(0, 127));
            end
        endcase
        return op;
    endfunction

    task automatic flags_chk();
        check("cycle_count", cycle_count, m_cyc);
        check("instret", instret_count, m_ret);
        check("illegal", 64'(illegal_instr), 64'(m_ill));
        check("bus_error", 64'(bus_error), 64'(m_bus));
    endtask

    // One clock: drive readies, check strobes mid-cycle, then counters/flags.
    task automatic cycle(input logic [11:0] eo, input logic ir,
                         input logic dr, input int ev);
        imem_ready = ir;
        dmem_ready = dr;
        #3;
        check("ctl", 64'(ctl), 64'(eo));
        @(posedge clk);
        #1;
        if (!m_trap) m_cyc++;
        if (ev == EV_RET) m_ret++;
        if (ev == EV_ILL) begin m_ill = 1'b1; m_trap = 1'b1; end
        if (ev == EV_BUS) begin m_bus = 1'b1; m_trap = 1'b1; end
        flags_chk();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            imem_ready = rnd();
            dmem_ready = 1'b1;
            #3;
            check("rst_ctl", 64'(ctl), 64'd0);
            @(posedge clk);
            #1;
            m_cyc = '0; m_ret = '0;
            m_ill = 1'b0; m_bus = 1'b0; m_trap = 1'b0;
            flags_chk();
        end
        reset = 1'b1;
    endtask

    // Up to TMO cycles of waiting for ready; ready on wait index w completes.
    task automatic wait_phase(input bit imem, input int w,
                              input logic [11:0] base, input logic [11:0] done,
                              input int done_ev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            if (i == w) begin
                cycle(base | done, imem ? 1'b1 : rnd(), imem ? rnd() : 1'b1,
                      done_ev);
                ok = 1'b1;
                return;
            end
            cycle(base, imem ? 1'b0 : rnd(), imem ? rnd() : 1'b0,
                  (i == TMO - 1) ? EV_BUS : EV_NONE);
        end
    endtask

    task automatic run_instr(input int k, input int wi, input int wd);
        bit ok;
        opcode = op_of(k);
        wait_phase(1'b1, wi, IREQ, IRW, EV_NONE, ok);
        if (!ok) return;
        cycle(12'h000, rnd(), rnd(), (k == K_ILL) ? EV_ILL : EV_NONE);
        case (k)
            K_R:  cycle(AFN, rnd(), rnd(), EV_NONE);
            K_I:  cycle(AFN | SRC2, rnd(), rnd(), EV_NONE);
            K_LD, K_ST: cycle(SRC2, rnd(), rnd(), EV_NONE);
            K_BR: begin
                cycle(BR | ASUB | PCW, rnd(), rnd(), EV_RET);
                return;
            end
            default: return;
        endcase
        if (k == K_ST) begin
            wait_phase(1'b0, wd, DREQ | MWR, PCW, EV_RET, ok);
            return;
        end
        if (k == K_LD) begin
            wait_phase(1'b0, wd, DREQ | MRD, 12'h000, EV_NONE, ok);
            if (!ok) return;
        end
        cycle(WREN | PCW | ((k == K_LD) ? M2R : 12'h000), rnd(), rnd(),
              EV_RET);
    endtask

    task automatic trap_idle(input int n);
        for (int i = 0; i < n; i++) cycle(12'h000, rnd(), rnd(), EV_NONE);
    endtask

    initial begin
        int k, wi, wd;
        reset = 1'b0;
        opcode = 7'd0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        m_cyc = '0; m_ret = '0;
        m_ill = 1'b0; m_bus = 1'b0; m_trap = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        run_instr(K_R, 0, 0);
        check("r_cyc4", cycle_count, 64'd4);
        check("r_ret1", instret_count, 64'd1);
        run_instr(K_LD, 0, 3);
        run_instr(K_BR, 0, 0);
        run_instr(K_I, 1, 0);
        run_instr(K_ST, 0, 2);

        opcode = 7'b1111111;
        run_instr(K_ILL, 0, 0);
        trap_idle(20);
        do_reset(2);

        run_instr(K_R, TMO, 0);
        trap_idle(20);
        do_reset(1);
        run_instr(K_R, TMO - 1, 0);
        run_instr(K_LD, 0, TMO);
        trap_idle(5);
        do_reset(1);
        run_instr(K_ST, 0, TMO - 1);

        // STORE abandoned by reset while waiting on dmem
        opcode = 7'b0100011;
        cycle(IREQ | IRW, 1'b1, rnd(), EV_NONE);
        cycle(12'h000, rnd(), rnd(), EV_NONE);
        cycle(SRC2, rnd(), rnd(), EV_NONE);
        cycle(DREQ | MWR, rnd(), 1'b0, EV_NONE);
        cycle(DREQ | MWR, rnd(), 1'b0, EV_NONE);
        do_reset(1);
        run_instr(K_BR, 0, 0);

        for (int n = 0; n < 200; n++) begin
            k  = ($urandom_range(0, 9) == 0) ? K_ILL : $urandom_range(0, 4);
            wi = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, TMO - 1);
            wd = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, TMO - 1);
            run_instr(k, wi, wd);
            if (m_trap) begin
                trap_idle(3);
                do_reset($urandom_range(1, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
